// File: rtl/end_screen_ctrl_if.sv
// Game-over screen bus bundle: control inputs, live score, VGA pass-through
// and the captured/derived score outputs. master = driver side (game core),
// slave = end_screen_ctrl.
// VGA bus layout (low 32 bits): [31:22] pixel x, [21:12] pixel y, [11:0] rgb.
`ifndef VGA_BUS_SIZE
`define VGA_BUS_SIZE 32
`endif

interface end_screen_ctrl_if #(
  parameter int DIGITS = 3
);
  logic                     module_en;
  logic                     jump_fail;
  logic                     one_sec_tick;
  logic [4*DIGITS-1:0]      score;
  logic [`VGA_BUS_SIZE-1:0] vga_bus_in;
  logic [`VGA_BUS_SIZE-1:0] vga_bus_out;
  logic [4*DIGITS-1:0]      final_score;
  logic [4*DIGITS-1:0]      high_score;
  logic                     new_record;
  logic                     hint_visible;

  modport master (
    output module_en, jump_fail, one_sec_tick, score, vga_bus_in,
    input  vga_bus_out, final_score, high_score, new_record, hint_visible
  );

  modport slave (
    input  module_en, jump_fail, one_sec_tick, score, vga_bus_in,
    output vga_bus_out, final_score, high_score, new_record, hint_visible
  );
endinterface

// File: rtl/end_screen_ctrl.sv
// end_screen_ctrl: game-over controller. Captures the final BCD score once per
// game-over entry (decremented by one on a failed jump), optionally tracks the
// best score, and sequences the blinking "press spacebar" hint. Three string
// overlays are chained on the VGA bus: game_end -> score_end -> spacebar.
// Optional feature macro: HIGH_SCORE_EN (high score register + BCD compare).
// Without it high_score/new_record are tied low; sequence timing is unchanged.
//
//   state     | meaning
//   ----------+--------------------------------------------------------------
//   OFF       | screen inactive; waits for module_en rise, captures score
//   LATCH     | one cycle: update high score, clear tick counter
//   REVEAL    | hint hidden; counts REVEAL_TICKS seconds
//   BLINK_ON  | hint shown; counts BLINK_TICKS seconds
//   BLINK_OFF | hint hidden; counts BLINK_TICKS seconds

// Solid rectangle overlay on the VGA bus; replaces rgb inside [X0,X1)x[Y0,Y1).
module vga_box #(
  parameter logic [9:0] X0 = 10'd1,
  parameter logic [9:0] X1 = 10'd2,
  parameter logic [9:0] Y0 = 10'd1,
  parameter logic [9:0] Y1 = 10'd2
) (
  input  logic                     en,
  input  logic [11:0]              color,
  input  logic [`VGA_BUS_SIZE-1:0] bus_in,
  output logic [`VGA_BUS_SIZE-1:0] bus_out
);
  logic [9:0] px;
  logic [9:0] py;
  logic       hit;

  assign px  = bus_in[31:22];
  assign py  = bus_in[21:12];
  assign hit = en && (px >= X0) && (px < X1) && (py >= Y0) && (py < Y1);

  // Overlay colour only inside the box; everything else passes through.
  always_comb begin
    bus_out = bus_in;
    if (hit) bus_out[11:0] = color;
  end
endmodule

// "GAME OVER" banner: red after a failed jump, yellow otherwise.
module string_game_end (
  input  logic                     module_en,
  input  logic                     jump_fail,
  input  logic [`VGA_BUS_SIZE-1:0] vga_bus_in,
  output logic [`VGA_BUS_SIZE-1:0] vga_bus_out
);
  vga_box #(.X0(10'd100), .X1(10'd540), .Y0(10'd100), .Y1(10'd140)) u_box (
    .en      (module_en),
    .color   (jump_fail ? 12'hF00 : 12'hFF0),
    .bus_in  (vga_bus_in),
    .bus_out (vga_bus_out)
  );
endmodule

// Score field: the three displayed BCD digits drive the fill colour.
module string_score_end (
  input  logic                     module_en,
  input  logic [11:0]              score,
  input  logic [`VGA_BUS_SIZE-1:0] vga_bus_in,
  output logic [`VGA_BUS_SIZE-1:0] vga_bus_out
);
  vga_box #(.X0(10'd260), .X1(10'd380), .Y0(10'd200), .Y1(10'd240)) u_box (
    .en      (module_en),
    .color   (score),
    .bus_in  (vga_bus_in),
    .bus_out (vga_bus_out)
  );
endmodule

// "press spacebar" hint box, white.
module string_spacebar (
  input  logic                     module_en,
  input  logic [`VGA_BUS_SIZE-1:0] vga_bus_in,
  output logic [`VGA_BUS_SIZE-1:0] vga_bus_out
);
  vga_box #(.X0(10'd160), .X1(10'd480), .Y0(10'd320), .Y1(10'd360)) u_box (
    .en      (module_en),
    .color   (12'hFFF),
    .bus_in  (vga_bus_in),
    .bus_out (vga_bus_out)
  );
endmodule

module end_screen_ctrl #(
  parameter int DIGITS       = 3,
  parameter int REVEAL_TICKS = 2,
  parameter int BLINK_TICKS  = 1
) (
  input  logic              clk,
  input  logic              rst,
  end_screen_ctrl_if.slave  bus
);
  localparam int W      = 4 * DIGITS;
  localparam int MAX_T  = (REVEAL_TICKS > BLINK_TICKS) ? REVEAL_TICKS : BLINK_TICKS;
  localparam int CW     = $clog2(MAX_T + 1);
  localparam logic [CW-1:0] REVEAL_TC = CW'(REVEAL_TICKS - 1);
  localparam logic [CW-1:0] BLINK_TC  = CW'(BLINK_TICKS - 1);

  typedef enum logic [2:0] {
    OFF       = 3'd0,
    LATCH     = 3'd1,
    REVEAL    = 3'd2,
    BLINK_ON  = 3'd3,
    BLINK_OFF = 3'd4
  } state_t;

  state_t          state;
  state_t          state_next;
  logic            en_d;
  logic            rise;
  logic [CW-1:0]   tick_cnt;
  logic            capture;
  logic            cnt_clr;
  logic            cnt_inc;
  logic [W-1:0]    final_score;
  logic [W-1:0]    high_score;
  logic            new_record;
  logic            hint_visible;
  logic [`VGA_BUS_SIZE-1:0] vga_a;
  logic [`VGA_BUS_SIZE-1:0] vga_b;

  // BCD decrement by one with borrow rippling up through all digits.
  function automatic logic [W-1:0] bcd_dec(input logic [W-1:0] s);
    logic [W-1:0] r;
    logic         borrow;
    r      = s;
    borrow = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (borrow) begin
        if (s[4*i +: 4] == 4'd0) begin
          r[4*i +: 4] = 4'd9;
        end else begin
          r[4*i +: 4] = s[4*i +: 4] - 4'd1;
          borrow      = 1'b0;
        end
      end
    end
    return r;
  endfunction

  // Failed jump costs one point; a zero score never underflows.
  function automatic logic [W-1:0] corr(input logic [W-1:0] s, input logic f);
    if (!f || (s == '0)) return s;
    return bcd_dec(s);
  endfunction

  assign rise = bus.module_en & ~en_d;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= OFF;
    else     state <= state_next;
  end

  // Next-state decode plus datapath strobes; dropping module_en always aborts.
  always_comb begin
    state_next = state;
    capture    = 1'b0;
    cnt_clr    = 1'b0;
    cnt_inc    = 1'b0;
    if (!bus.module_en) begin
      state_next = OFF;
    end else begin
      case (state)
        OFF: begin
          if (rise) begin
            capture    = 1'b1;
            state_next = LATCH;
          end
        end
        LATCH: begin
          cnt_clr    = 1'b1;
          state_next = REVEAL;
        end
        REVEAL: begin
          if (bus.one_sec_tick) begin
            if (tick_cnt == REVEAL_TC) begin
              cnt_clr    = 1'b1;
              state_next = BLINK_ON;
            end else begin
              cnt_inc = 1'b1;
            end
          end
        end
        BLINK_ON: begin
          if (bus.one_sec_tick) begin
            if (tick_cnt == BLINK_TC) begin
              cnt_clr    = 1'b1;
              state_next = BLINK_OFF;
            end else begin
              cnt_inc = 1'b1;
            end
          end
        end
        BLINK_OFF: begin
          if (bus.one_sec_tick) begin
            if (tick_cnt == BLINK_TC) begin
              cnt_clr    = 1'b1;
              state_next = BLINK_ON;
            end else begin
              cnt_inc = 1'b1;
            end
          end
        end
        default: state_next = OFF;
      endcase
    end
  end

  // Edge-detect history, second counter, score capture and hint register.
  // hint_visible decodes the next state so it rises with BLINK_ON itself.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      en_d         <= 1'b0;
      tick_cnt     <= '0;
      final_score  <= '0;
      hint_visible <= 1'b0;
    end else begin
      en_d <= bus.module_en;
      if (cnt_clr)      tick_cnt <= '0;
      else if (cnt_inc) tick_cnt <= tick_cnt + CW'(1);
      if (capture) final_score <= corr(bus.score, bus.jump_fail);
      hint_visible <= (state_next == BLINK_ON);
    end
  end

`ifdef HIGH_SCORE_EN
  // Digit-wise BCD greater-than, most significant digit decides first.
  function automatic logic bcd_gt(input logic [W-1:0] a, input logic [W-1:0] b);
    logic gt;
    logic decided;
    gt      = 1'b0;
    decided = 1'b0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      if (!decided && (a[4*i +: 4] != b[4*i +: 4])) begin
        gt      = (a[4*i +: 4] > b[4*i +: 4]);
        decided = 1'b1;
      end
    end
    return gt;
  endfunction

  // Best-score tracking: updated in LATCH, record flag dropped back in OFF.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      high_score <= '0;
      new_record <= 1'b0;
    end else if (state == OFF) begin
      new_record <= 1'b0;
    end else if ((state == LATCH) && bus.module_en && bcd_gt(final_score, high_score)) begin
      high_score <= final_score;
      new_record <= 1'b1;
    end
  end
`else
  assign high_score = '0;
  assign new_record = 1'b0;
`endif

  assign bus.final_score  = final_score;
  assign bus.high_score   = high_score;
  assign bus.new_record   = new_record;
  assign bus.hint_visible = hint_visible;

  string_game_end u_game_end (
    .module_en   (bus.module_en),
    .jump_fail   (bus.jump_fail),
    .vga_bus_in  (bus.vga_bus_in),
    .vga_bus_out (vga_a)
  );

  string_score_end u_score_end (
    .module_en   (bus.module_en),
    .score       (final_score[11:0]),
    .vga_bus_in  (vga_a),
    .vga_bus_out (vga_b)
  );

  string_spacebar u_spacebar (
    .module_en   (bus.module_en & hint_visible),
    .vga_bus_in  (vga_b),
    .vga_bus_out (bus.vga_bus_out)
  );
endmodule
